// File: rtl/fifo_packet_writer_if.sv
// Bundles the upstream byte stream, FIFO write port and status of fifo_packet_writer.
// master = upstream/FIFO side; slave = the packet writer itself.
interface fifo_packet_writer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  in_ready;
    logic                  fifo_full;
    logic                  fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_wr_data;
    logic                  pkt_sent;
    logic                  busy;

    modport master (
        output in_valid, in_data, in_last, fifo_full,
        input  in_ready, fifo_wr_en, fifo_wr_data, pkt_sent, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, fifo_full,
        output in_ready, fifo_wr_en, fifo_wr_data, pkt_sent, busy
    );
endinterface

// File: rtl/fifo_packet_writer.sv
// Stages a whole packet, then pushes {trunc, length} followed by the payload into the async FIFO,
// so the read side never observes a partial packet.
module fifo_packet_writer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_LEN    = 64
) (
    input  logic                 write_clk,
    input  logic                 reset,
    fifo_packet_writer_if.slave  bus
);
    localparam int unsigned CntW = $clog2(MAX_LEN + 1);
    localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned LenW = DATA_WIDTH - 1;
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_LEN);

    typedef enum logic [1:0] {StIdle, StCollect, StHeader, StPayload} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic                  trunc_q, trunc_d;
    logic                  pkt_sent_q, pkt_sent_d;
    logic                  busy_q, busy_d;
    logic                  in_ready_q, in_ready_d;

    logic [DATA_WIDTH-1:0] stage_q [MAX_LEN];
    logic                  stage_we;
    logic [IdxW-1:0]       stage_addr;

    logic                  accept;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;

    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        trunc_d    = trunc_q;
        pkt_sent_d = 1'b0;
        stage_we   = 1'b0;
        stage_addr = IdxW'(count_q);
        wr_en      = 1'b0;
        wr_data    = '0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    stage_we   = 1'b1;
                    stage_addr = '0;
                    count_d    = CntW'(1);
                    state_d    = bus.in_last ? StHeader : StCollect;
                end
            end
            StCollect: begin
                if (accept) begin
                    // Beats past MAX_LEN are still consumed so upstream never stalls mid-packet.
                    if (count_q < MaxCnt) begin
                        stage_we = 1'b1;
                        count_d  = count_q + CntW'(1);
                    end else begin
                        trunc_d = 1'b1;
                    end
                    if (bus.in_last) state_d = StHeader;
                end
            end
            StHeader: begin
                wr_en   = !bus.fifo_full;
                wr_data = {trunc_q, LenW'(count_q)};
                if (wr_en) begin
                    state_d = StPayload;
                    idx_d   = '0;
                end
            end
            StPayload: begin
                wr_en   = !bus.fifo_full;
                wr_data = stage_q[idx_q];
                if (wr_en) begin
                    if (CntW'(idx_q) == count_q - CntW'(1)) begin
                        state_d    = StIdle;
                        count_d    = '0;
                        idx_d      = '0;
                        trunc_d    = 1'b0;
                        pkt_sent_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d     = (state_d != StIdle);
        in_ready_d = (state_d == StIdle) || (state_d == StCollect);
    end

    always_ff @(posedge write_clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            idx_q      <= '0;
            trunc_q    <= 1'b0;
            pkt_sent_q <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            trunc_q    <= trunc_d;
            pkt_sent_q <= pkt_sent_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Staging buffer is intentionally unreset; only [0, count) is ever read.
    always_ff @(posedge write_clk) begin
        if (stage_we) stage_q[stage_addr] <= bus.in_data;
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.fifo_wr_en   = wr_en;
    assign bus.fifo_wr_data = wr_data;
    assign bus.pkt_sent     = pkt_sent_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_fifo_packet_writer.sv
// Directed bench: per-cycle vector table on a MAX_LEN=64 instance, plus hand sequences for
// truncation (MAX_LEN=4 instance) and asynchronous reset mid-drain.
module tb_fifo_packet_writer;
    logic clk;
    logic rst_a;
    logic rst_t;

    fifo_packet_writer_if #(.DATA_WIDTH(8)) bus_a ();
    fifo_packet_writer_if #(.DATA_WIDTH(8)) bus_t ();

    fifo_packet_writer #(.DATA_WIDTH(8), .MAX_LEN(64)) dut_a (
        .write_clk (clk),
        .reset     (rst_a),
        .bus       (bus_a)
    );

    fifo_packet_writer #(.DATA_WIDTH(8), .MAX_LEN(4)) dut_t (
        .write_clk (clk),
        .reset     (rst_t),
        .bus       (bus_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       f;
        logic       rdy;
        logic       wen;
        logic [7:0] wd;
        logic       sent;
        logic       busy;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] cap[$];
    logic [7:0] exp_q[$];
    int         n_vec;
    int         n_bad;

    logic       o_rdy, o_wen, o_sent, o_busy;
    logic [7:0] o_wd;

    function automatic vec_t mk(input int v, input int d, input int l, input int f,
                                input int rdy, input int wen, input int wd,
                                input int sent, input int busy);
        vec_t r;
        r.v    = 1'(v);
        r.d    = 8'(d);
        r.l    = 1'(l);
        r.f    = 1'(f);
        r.rdy  = 1'(rdy);
        r.wen  = 1'(wen);
        r.wd   = 8'(wd);
        r.sent = 1'(sent);
        r.busy = 1'(busy);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic sample(input bit sel);
        if (sel) begin
            o_rdy = bus_t.in_ready; o_wen = bus_t.fifo_wr_en; o_wd = bus_t.fifo_wr_data;
            o_sent = bus_t.pkt_sent; o_busy = bus_t.busy;
        end else begin
            o_rdy = bus_a.in_ready; o_wen = bus_a.fifo_wr_en; o_wd = bus_a.fifo_wr_data;
            o_sent = bus_a.pkt_sent; o_busy = bus_a.busy;
        end
    endtask

    // Drive one cycle's inputs after the falling edge, sample before the next rising edge.
    task automatic cycle(input bit sel, input logic v, input logic [7:0] d, input logic l,
                         input logic f);
        @(negedge clk);
        if (sel) begin
            bus_t.in_valid = v; bus_t.in_data = d; bus_t.in_last = l; bus_t.fifo_full = f;
        end else begin
            bus_a.in_valid = v; bus_a.in_data = d; bus_a.in_last = l; bus_a.fifo_full = f;
        end
        #1;
        sample(sel);
        if (o_wen) cap.push_back(o_wd);
    endtask

    task automatic drain(input bit sel, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(sel, 1'b0, 8'h00, 1'b0, 1'b0);
            if (o_sent) seen = 1'b1;
        end
        check({name, "_sent_seen"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic compare_cap(input string name);
        check({name, "_len"}, cap.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < cap.size()) check($sformatf("%s_word%0d", name, i), {24'd0, cap[i]},
                                      {24'd0, exp_q[i]});
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_a = 1'b1;
        rst_t = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_last = 1'b0; bus_a.fifo_full = 1'b0;
        bus_t.in_valid = 1'b0; bus_t.in_data = '0; bus_t.in_last = 1'b0; bus_t.fifo_full = 1'b0;

        // 3-beat packet, no backpressure
        vecs.push_back(mk(1, 'hA1, 0, 0, 1, 0, 'h00, 0, 0));
        vecs.push_back(mk(1, 'hA2, 0, 0, 1, 0, 'h00, 0, 1));
        vecs.push_back(mk(1, 'hA3, 1, 0, 1, 0, 'h00, 0, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 0, 1, 'h03, 0, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 0, 1, 'hA1, 0, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 0, 1, 'hA2, 0, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 0, 1, 'hA3, 0, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 1, 0, 'h00, 1, 0));
        // Same packet, fifo_full for 5 cycles right after the header push
        vecs.push_back(mk(1, 'hA1, 0, 0, 1, 0, 'h00, 0, 0));
        vecs.push_back(mk(1, 'hA2, 0, 0, 1, 0, 'h00, 0, 1));
        vecs.push_back(mk(1, 'hA3, 1, 0, 1, 0, 'h00, 0, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 0, 1, 'h03, 0, 1));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 'h00, 0, 1, 0, 0, 'hA1, 0, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 0, 1, 'hA1, 0, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 0, 1, 'hA2, 0, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 0, 1, 'hA3, 0, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 1, 0, 'h00, 1, 0));
        // 1-beat packet, header stalled for 2 cycles
        vecs.push_back(mk(1, 'h5C, 1, 0, 1, 0, 'h00, 0, 0));
        vecs.push_back(mk(0, 'h00, 0, 1, 0, 0, 'h01, 0, 1));
        vecs.push_back(mk(0, 'h00, 0, 1, 0, 0, 'h01, 0, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 0, 1, 'h01, 0, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 0, 1, 'h5C, 0, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 1, 0, 'h00, 1, 0));
        // Back-to-back 2-beat packets, in_valid held high; C1 waits through the drain
        vecs.push_back(mk(1, 'hB1, 0, 0, 1, 0, 'h00, 0, 0));
        vecs.push_back(mk(1, 'hB2, 1, 0, 1, 0, 'h00, 0, 1));
        vecs.push_back(mk(1, 'hC1, 0, 0, 0, 1, 'h02, 0, 1));
        vecs.push_back(mk(1, 'hC1, 0, 0, 0, 1, 'hB1, 0, 1));
        vecs.push_back(mk(1, 'hC1, 0, 0, 0, 1, 'hB2, 0, 1));
        vecs.push_back(mk(1, 'hC1, 0, 0, 1, 0, 'h00, 1, 0));
        vecs.push_back(mk(1, 'hC2, 1, 0, 1, 0, 'h00, 0, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 0, 1, 'h02, 0, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 0, 1, 'hC1, 0, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 0, 1, 'hC2, 0, 1));
        vecs.push_back(mk(0, 'h00, 0, 0, 1, 0, 'h00, 1, 0));
        vecs.push_back(mk(0, 'h00, 0, 0, 1, 0, 'h00, 0, 0));

        repeat (2) @(negedge clk);
        #1;
        sample(1'b0);
        check("reset_state_a", {27'd0, o_rdy, o_wen, o_sent, o_busy, 1'b0},
              {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        check("reset_wdata_a", {24'd0, o_wd}, 32'd0);
        sample(1'b1);
        check("reset_state_t", {28'd0, o_rdy, o_wen, o_sent, o_busy}, {28'd0, 4'b1000});
        @(negedge clk);
        rst_a = 1'b0;
        rst_t = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(1'b0, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].f);
            check($sformatf("vec%0d {rdy,wen,wd,sent,busy}", i),
                  {20'd0, o_rdy, o_wen, o_wd, o_sent, o_busy},
                  {20'd0, vecs[i].rdy, vecs[i].wen, vecs[i].wd, vecs[i].sent, vecs[i].busy});
        end

        // Truncation: MAX_LEN=4, 6 beats; the last two are accepted but dropped
        cap.delete();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, 8'(8'h10 + i), (i == 5), 1'b0);
            check($sformatf("trunc_ready%0d", i), {31'd0, o_rdy}, 32'd1);
        end
        drain(1'b1, "trunc");
        exp_q = '{8'h84, 8'h10, 8'h11, 8'h12, 8'h13};
        compare_cap("trunc");

        // Reset after header and one payload word of a 5-beat packet
        cap.delete();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(8'h31 + i), (i == 4), 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("pre_reset_wen", {31'd0, o_wen}, 32'd1);
        exp_q = '{8'h05, 8'h31, 8'h32};
        compare_cap("pre_reset");
        #1 rst_a = 1'b1;
        #1;
        sample(1'b0);
        check("async_reset {rdy,wen,busy}", {29'd0, o_rdy, o_wen, o_busy}, {29'd0, 3'b100});
        @(negedge clk);
        rst_a = 1'b0;
        cap.delete();
        cycle(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
        drain(1'b0, "post_reset");
        exp_q = '{8'h02, 8'h01, 8'h02};
        compare_cap("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_packet_writer.md
Name: fifo_packet_writer

Overview:
- Write-side producer for the team's dual-clock async FIFO, running entirely in the write_clk domain.
- Accepts a valid/ready byte stream from upstream logic and stores each packet in a local staging buffer.
- Once the packet is complete, pushes a length header followed by the payload into the FIFO's write port, with flow control against fifo_full.
- The read-domain consumer can therefore parse length-prefixed packets without ever seeing a partial packet in the FIFO.

Parameters:
- DATA_WIDTH, 8, width of payload beats and FIFO words; must be >= 8.
- MAX_LEN, 64, staging buffer depth in beats; must satisfy 1 <= MAX_LEN <= 2^(DATA_WIDTH-1)-1.

Ports:
- write_clk  input  1  write-domain clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  upstream beat valid.
- in_data  input  DATA_WIDTH  upstream beat data.
- in_last  input  1  marks the final beat of a packet.
- in_ready  output  1  block can accept a beat this cycle.
- fifo_full  input  1  FIFO full flag from the write domain.
- fifo_wr_en  output  1  FIFO write enable; a push occurs at each write_clk edge where this is 1.
- fifo_wr_data  output  DATA_WIDTH  FIFO write data.
- pkt_sent  output  1  one-cycle pulse on the edge after the last payload word of a packet is pushed.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Interface (decided): reset is asynchronous and active-high; the clock is write_clk.
- Reset values: state=IDLE; length count, drain index and trunc flag = 0; pkt_sent=0; busy=0; in_ready=1.
- fifo_wr_en and fifo_wr_data are combinational. In IDLE and COLLECT, fifo_wr_en=0 and fifo_wr_data=0.
- Beat acceptance: a beat is accepted on an edge where in_valid && in_ready.
- IDLE (in_ready=1):
  - Accepted beat is stored at buf[0]; count becomes 1.
  - If in_last is also high, go to HEADER; otherwise go to COLLECT.
- COLLECT (in_ready=1):
  - Accepted beat with count < MAX_LEN: store at buf[count]; count increments.
  - Accepted beat with count == MAX_LEN: discard it and set trunc=1; count stays at MAX_LEN.
  - An accepted beat with in_last moves the block to HEADER after that beat is stored or discarded.
- HEADER (in_ready=0):
  - fifo_wr_en = !fifo_full.
  - fifo_wr_data = {trunc, count zero-extended to DATA_WIDTH-1 bits}.
  - On push, go to PAYLOAD with idx=0.
- PAYLOAD (in_ready=0):
  - fifo_wr_en = !fifo_full; fifo_wr_data = buf[idx].
  - On push with idx < count-1, idx increments.
  - On push with idx == count-1, go to IDLE, pulse pkt_sent on the next cycle, and clear count, idx and trunc.
- fifo_full stall: holds state, idx and data unchanged and keeps fifo_wr_en=0. No push is ever issued while fifo_full=1.
- Latency: the header is presented on the cycle after the last beat is accepted. With no backpressure, an N-beat packet drains in N+1 consecutive cycles.
- Back-to-back packets: in IDLE, in_ready=1 in the same cycle the previous packet's pkt_sent pulse is high, so a new first beat is accepted immediately.
- Zero-length packets cannot occur; the first beat always counts.
- Truncated packets: the header length field equals MAX_LEN, bit DATA_WIDTH-1 is set, and only the first MAX_LEN beats are pushed.
- Reset mid-operation: any partially collected or partially drained packet is abandoned, and fifo_wr_en goes to 0 immediately (asynchronously). After reset release, no remnant of the abandoned packet is ever pushed.
- Staging buffer: a register array with combinational read. It is not reset; its contents are don't-care outside the valid range.

Test Plan:
- 3-beat packet 0xA1,0xA2,0xA3 (last on 0xA3), fifo_full=0 -> pushes 0x03,0xA1,0xA2,0xA3 on 4 consecutive edges starting the cycle after 0xA3 is accepted; in_ready=0 for exactly those 4 cycles; pkt_sent pulses once.
- Same packet with fifo_full=1 for 5 cycles starting just after the header push -> no pushes during the stall; 0xA1 stays on fifo_wr_data; the remaining sequence resumes intact.
- 1-beat packet 0x5C with in_last -> IDLE to HEADER directly; pushes 0x01,0x5C.
- MAX_LEN=4, 6 beats 0x10..0x15 with last on 0x15 -> pushes 0x84,0x10,0x11,0x12,0x13; beats 0x14 and 0x15 are accepted but never pushed.
- Reset asserted after the header and one payload word of a 5-beat packet -> fifo_wr_en=0 immediately; after release a new 2-beat packet 0x01,0x02 pushes exactly 0x02,0x01,0x02.
- Two back-to-back 2-beat packets with in_valid held high -> second packet's first beat is accepted in the pkt_sent cycle; FIFO receives two correctly framed packets with no gaps beyond the required in_ready=0 drain windows.
